// File: rtl/lsq_pkg.sv
// rtl/lsq_pkg.sv - shared op and state types for the load/store queue memory path
package lsq_pkg;

  typedef enum logic {
    OP_LOAD  = 1'b0,
    OP_STORE = 1'b1
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } mau_state_e;

endpackage

// File: rtl/timeout_counter.sv
// rtl/timeout_counter.sv - saturating REQ-phase cycle counter with expiry strobe
module timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic async_rst,
  input  logic clk_en,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != LIMIT)) begin
      count_d = count_q + CW'(1);
    end
  end

  // Strobes on the increment that reaches the limit, so REQ lasts exactly TIMEOUT_CYCLES cycles.
  assign expired = inc && !clear && (count_q == LAST);

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      count_q <= '0;
    end else if (clk_en) begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - runs one committed LSQ op at a time on a four-phase req/ack memory port
module mem_access_unit
  import lsq_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      async_rst,
  input  logic                      clk_en,
  input  logic                      lsq_valid,
  output logic                      lsq_ready,
  input  logic                      lsq_load_store,
  input  logic [MEM_ADDR_WIDTH-1:0] lsq_addr,
  input  logic [DATA_WIDTH-1:0]     lsq_data,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic                      mem_ack,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic                      load_valid,
  output logic [DATA_WIDTH-1:0]     load_data,
  output logic                      misalign_err,
  output logic                      timeout_err
);

  // Low address bits that must be zero for a word-aligned access; empty mask for byte-wide data.
  localparam logic [MEM_ADDR_WIDTH-1:0] ALIGN_MASK = MEM_ADDR_WIDTH'(DATA_WIDTH / 8 - 1);

  mau_state_e                state_q, state_d;
  mem_op_e                   op_q, op_d;
  logic                      mem_req_q, mem_req_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
  logic                      load_valid_q, load_valid_d;
  logic [DATA_WIDTH-1:0]     load_data_q, load_data_d;
  logic                      misalign_q, misalign_d;
  logic                      timeout_err_q, timeout_err_d;

  logic accept;
  logic misaligned;
  logic cnt_clear;
  logic cnt_inc;
  logic cnt_expired;

  assign lsq_ready  = (state_q == IDLE) && clk_en;
  assign accept     = lsq_valid && lsq_ready;
  assign misaligned = |(lsq_addr & ALIGN_MASK);

  timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_counter (
    .clk      (clk),
    .async_rst(async_rst),
    .clk_en   (clk_en),
    .clear    (cnt_clear),
    .inc      (cnt_inc),
    .expired  (cnt_expired)
  );

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    load_valid_d  = 1'b0;
    load_data_d   = load_data_q;
    misalign_d    = 1'b0;
    timeout_err_d = timeout_err_q;
    cnt_clear     = 1'b0;
    cnt_inc       = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (misaligned) begin
            misalign_d = 1'b1;
          end else begin
            state_d     = REQ;
            op_d        = mem_op_e'(lsq_load_store);
            mem_req_d   = 1'b1;
            mem_addr_d  = lsq_addr;
            mem_wdata_d = lsq_data;
            cnt_clear   = 1'b1;
          end
        end
      end

      REQ: begin
        cnt_inc = 1'b1;
        // An ack on the expiry cycle still completes the op.
        if (mem_ack) begin
          state_d   = RELEASE;
          mem_req_d = 1'b0;
          if (op_q == OP_LOAD) begin
            load_valid_d = 1'b1;
            load_data_d  = mem_rdata;
          end
        end else if (cnt_expired) begin
          state_d       = RELEASE;
          mem_req_d     = 1'b0;
          timeout_err_d = 1'b1;
        end
      end

      RELEASE: begin
        if (!mem_ack) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge async_rst) begin
    if (async_rst) begin
      state_q       <= IDLE;
      op_q          <= OP_LOAD;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      load_valid_q  <= 1'b0;
      load_data_q   <= '0;
      misalign_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else if (clk_en) begin
      state_q       <= state_d;
      op_q          <= op_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      load_valid_q  <= load_valid_d;
      load_data_q   <= load_data_d;
      misalign_q    <= misalign_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign mem_req      = mem_req_q;
  assign mem_we       = op_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign load_valid   = load_valid_q;
  assign load_data    = load_data_q;
  assign misalign_err = misalign_q;
  assign timeout_err  = timeout_err_q;

endmodule
